// File: rtl/reg_file_scb.sv
// Dual-write, multi-read register file with a per-register busy scoreboard and LC-3 style
// condition codes. Reads are combinational, with optional same-cycle forwarding of write data.
module reg_file_scb #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr0_en,
  input  logic [AW-1:0]            wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr0_setcc,
  input  logic                     wr1_en,
  input  logic [AW-1:0]            wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     rsv_valid,
  input  logic [AW-1:0]            rsv_addr,
  output logic                     rsv_ready,
  output logic [2:0]               nzp
);

  logic [DATA_W-1:0] w_mem [NUM_REGS];
  logic [NUM_REGS-1:0] w_busy;
  logic              w_rsv_hit_wr;
  logic              w_rsv_take;
  logic [2:0]        r_nzp;

  // A write landing on the reserved register this cycle frees it, so the new
  // reservation can be granted in the same cycle (release-and-reserve).
  assign w_rsv_hit_wr = (wr0_en && (wr0_addr == rsv_addr)) ||
                        (wr1_en && (wr1_addr == rsv_addr));
  assign rsv_ready    = !w_busy[rsv_addr] || w_rsv_hit_wr;
  assign w_rsv_take   = rsv_valid && rsv_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic              w_hit0;
      logic              w_hit1;
      logic              w_rsv_here;
      logic [DATA_W-1:0] r_data;
      logic              r_busy;

      assign w_hit0     = wr0_en && (wr0_addr == AW'(gi));
      assign w_hit1     = wr1_en && (wr1_addr == AW'(gi));
      assign w_rsv_here = w_rsv_take && (rsv_addr == AW'(gi));

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_data <= '0;
        end else if (w_hit1) begin
          r_data <= wr1_data;
        end else if (w_hit0) begin
          r_data <= wr0_data;
        end
      end

      // Reservation takes priority so a same-cycle write+reserve leaves the register busy.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_busy <= 1'b0;
        end else if (w_rsv_here) begin
          r_busy <= 1'b1;
        end else if (w_hit0 || w_hit1) begin
          r_busy <= 1'b0;
        end
      end

      assign w_mem[gi]  = r_data;
      assign w_busy[gi] = r_busy;
    end

    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [AW-1:0]     w_raddr;
      logic [DATA_W-1:0] w_rdata;

      assign w_raddr = rd_addr[gi*AW +: AW];

      if (BYPASS != 0) begin : g_bypass
        always_comb begin
          w_rdata = w_mem[w_raddr];
          if (wr0_en && (wr0_addr == w_raddr)) begin
            w_rdata = wr0_data;
          end
          if (wr1_en && (wr1_addr == w_raddr)) begin
            w_rdata = wr1_data;
          end
        end
      end else begin : g_direct
        assign w_rdata = w_mem[w_raddr];
      end

      assign rd_data[gi*DATA_W +: DATA_W] = w_rdata;
      assign rd_busy[gi]                  = w_busy[w_raddr];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_nzp <= 3'b010;
    end else if (wr0_en && wr0_setcc) begin
      if (wr0_data[DATA_W-1]) begin
        r_nzp <= 3'b100;
      end else if (wr0_data == '0) begin
        r_nzp <= 3'b010;
      end else begin
        r_nzp <= 3'b001;
      end
    end
  end

  assign nzp = r_nzp;

endmodule

// File: tb/tb_reg_file_scb.sv
// Directed bench for reg_file_scb: a forwarding instance and a non-forwarding instance
// share all inputs so read-during-write behaviour can be compared side by side.
module tb_reg_file_scb;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr0_en, wr1_en, wr0_setcc, rsv_valid;
  logic [2:0]  wr0_addr, wr1_addr, rsv_addr;
  logic [15:0] wr0_data, wr1_data;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data, rd_data_nb;
  logic [1:0]  rd_busy, rd_busy_nb;
  logic        rsv_ready, rsv_ready_nb;
  logic [2:0]  nzp, nzp_nb;

  int checks = 0;
  int errors = 0;

  reg_file_scb #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(2), .BYPASS(1)) dut (
    .clk(clk), .reset(reset),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_setcc(wr0_setcc),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready), .nzp(nzp)
  );

  reg_file_scb #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(2), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_setcc(wr0_setcc),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready_nb), .nzp(nzp_nb)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr0_en = 1'b0; wr1_en = 1'b0; wr0_setcc = 1'b0; rsv_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    wr0_addr = 3'd0; wr1_addr = 3'd0; wr0_data = 16'h0; wr1_data = 16'h0;
    rsv_addr = 3'd0; rd_addr = 6'd0;
    tick(); tick();
    for (int r = 0; r < 8; r++) begin
      rd_addr[2:0] = 3'(r);
      #1;
      $display("txn reset read R%0d data=%h busy=%b", r, rd_data[15:0], rd_busy[0]);
      checks++;
      if (rd_data[15:0] !== 16'h0000) begin
        errors++; $display("FAIL reset_data R%0d got %h exp 0000", r, rd_data[15:0]);
      end
      checks++;
      if (rd_busy[0] !== 1'b0) begin
        errors++; $display("FAIL reset_busy R%0d got %b exp 0", r, rd_busy[0]);
      end
    end
    checks++;
    if (nzp !== 3'b010) begin
      errors++; $display("FAIL reset_nzp got %b exp 010", nzp);
    end
    // Write and reservation held across an edge while in reset must be discarded.
    wr0_en = 1'b1; wr0_addr = 3'd1; wr0_data = 16'h1234;
    rsv_valid = 1'b1; rsv_addr = 3'd1;
    tick();
    idle();
    #3 reset = 1'b0;
    // First write after release is taken on the very first edge.
    wr0_en = 1'b1; wr0_addr = 3'd1; wr0_data = 16'h00AA;
    rd_addr[2:0] = 3'd6;
    tick();
    idle();
    rd_addr[2:0] = 3'd1;
    #1;
    $display("txn first write R1 data=%h busy=%b", rd_data[15:0], rd_busy[0]);
    checks++;
    if (rd_data[15:0] !== 16'h00AA) begin
      errors++; $display("FAIL first_write got %h exp 00aa", rd_data[15:0]);
    end
    checks++;
    if (rd_busy[0] !== 1'b0) begin
      errors++; $display("FAIL reset_discard_rsv got %b exp 0", rd_busy[0]);
    end
  endtask

  task automatic test_bypass();
    rd_addr = {3'd3, 3'd3};
    wr0_en = 1'b1; wr0_addr = 3'd3; wr0_data = 16'hBEEF;
    #1;
    $display("txn bypass wr0 R3<=beef byp=%h nobyp=%h", rd_data[15:0], rd_data_nb[15:0]);
    checks++;
    if (rd_data[15:0] !== 16'hBEEF) begin
      errors++; $display("FAIL bypass_same_cycle got %h exp beef", rd_data[15:0]);
    end
    checks++;
    if (rd_data_nb[15:0] !== 16'h0000) begin
      errors++; $display("FAIL nobypass_old got %h exp 0000", rd_data_nb[15:0]);
    end
    tick();
    idle();
    #1;
    $display("txn bypass next cycle nobyp=%h", rd_data_nb[15:0]);
    checks++;
    if (rd_data_nb[15:0] !== 16'hBEEF) begin
      errors++; $display("FAIL nobypass_next got %h exp beef", rd_data_nb[15:0]);
    end
  endtask

  task automatic test_collision();
    rd_addr = {3'd5, 3'd5};
    wr0_en = 1'b1; wr0_addr = 3'd5; wr0_data = 16'h1111;
    wr1_en = 1'b1; wr1_addr = 3'd5; wr1_data = 16'h2222;
    #1;
    $display("txn collision bypass R5 data=%h", rd_data[31:16]);
    checks++;
    if (rd_data[31:16] !== 16'h2222) begin
      errors++; $display("FAIL bypass_wr1_wins got %h exp 2222", rd_data[31:16]);
    end
    tick();
    idle();
    #1;
    $display("txn collision stored R5 data=%h", rd_data_nb[15:0]);
    checks++;
    if (rd_data_nb[15:0] !== 16'h2222) begin
      errors++; $display("FAIL collision_store got %h exp 2222", rd_data_nb[15:0]);
    end
  endtask

  task automatic test_scoreboard();
    rd_addr = {3'd2, 3'd3};
    rsv_valid = 1'b1; rsv_addr = 3'd2;
    #1;
    checks++;
    if (rsv_ready !== 1'b1) begin
      errors++; $display("FAIL rsv_ready_free got %b exp 1", rsv_ready);
    end
    tick();
    rsv_valid = 1'b0;
    #1;
    $display("txn reserve R2 ready=%b busy=%b", rsv_ready, rd_busy);
    checks++;
    if (rsv_ready !== 1'b0) begin
      errors++; $display("FAIL rsv_ready_busy got %b exp 0", rsv_ready);
    end
    checks++;
    if (rd_busy !== 2'b10) begin
      errors++; $display("FAIL rd_busy_r2 got %b exp 10", rd_busy);
    end
    // Rejected reservation of R3 aliasing: valid on busy R2 must leave R3 untouched.
    rsv_valid = 1'b1;
    tick();
    rsv_valid = 1'b0;
    #1;
    checks++;
    if (rd_busy[0] !== 1'b0) begin
      errors++; $display("FAIL rejected_rsv_side got %b exp 0", rd_busy[0]);
    end
    wr1_en = 1'b1; wr1_addr = 3'd2; wr1_data = 16'h0007;
    rsv_valid = 1'b1;
    #1;
    $display("txn release+reserve R2 ready=%b", rsv_ready);
    checks++;
    if (rsv_ready !== 1'b1) begin
      errors++; $display("FAIL rsv_ready_release got %b exp 1", rsv_ready);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd_busy[1] !== 1'b1) begin
      errors++; $display("FAIL busy_after_release_reserve got %b exp 1", rd_busy[1]);
    end
    checks++;
    if (rd_data[31:16] !== 16'h0007) begin
      errors++; $display("FAIL r2_data got %h exp 0007", rd_data[31:16]);
    end
    wr0_en = 1'b1; wr0_addr = 3'd2; wr0_data = 16'h0009;
    wr1_en = 1'b1; wr1_addr = 3'd6; wr1_data = 16'h0006;
    tick();
    idle();
    rd_addr = {3'd2, 3'd6};
    #1;
    $display("txn write clears busy busy=%b", rd_busy);
    checks++;
    if (rd_busy !== 2'b00) begin
      errors++; $display("FAIL write_clears_busy got %b exp 00", rd_busy);
    end
  endtask

  task automatic test_cc();
    logic [15:0] vals [5] = '{16'h8000, 16'h0000, 16'hFFFF, 16'h0001, 16'h0042};
    logic        use1 [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        scc  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [2:0]  expc [5] = '{3'b100, 3'b010, 3'b010, 3'b010, 3'b001};
    for (int i = 0; i < 5; i++) begin
      wr0_addr = 3'd7; wr1_addr = 3'd7;
      wr0_data = vals[i]; wr1_data = vals[i];
      wr0_en = !use1[i]; wr1_en = use1[i]; wr0_setcc = scc[i];
      tick();
      idle();
      #1;
      $display("txn cc step %0d data=%h nzp=%b", i, vals[i], nzp);
      checks++;
      if (nzp !== expc[i]) begin
        errors++; $display("FAIL cc_step%0d got %b exp %b", i, nzp, expc[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    rd_addr = {3'd1, 3'd1};
    wr0_en = 1'b1; wr0_addr = 3'd1; wr0_data = 16'h00FF;
    tick();
    idle();
    rsv_valid = 1'b1; rsv_addr = 3'd1;
    tick();
    idle();
    #1;
    checks++;
    if (rd_data[15:0] !== 16'h00FF || rd_busy[0] !== 1'b1) begin
      errors++; $display("FAIL pre_reset got %h/%b exp 00ff/1", rd_data[15:0], rd_busy[0]);
    end
    reset = 1'b1;
    #1;
    $display("txn async reset data=%h busy=%b nzp=%b", rd_data[15:0], rd_busy[0], nzp);
    checks++;
    if (rd_data[15:0] !== 16'h0000) begin
      errors++; $display("FAIL async_data got %h exp 0000", rd_data[15:0]);
    end
    checks++;
    if (rd_busy[0] !== 1'b0) begin
      errors++; $display("FAIL async_busy got %b exp 0", rd_busy[0]);
    end
    checks++;
    if (nzp !== 3'b010) begin
      errors++; $display("FAIL async_nzp got %b exp 010", nzp);
    end
    #1 reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_collision();
    test_scoreboard();
    test_cc();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_scb.md
REG_FILE_SCB -- requirements
Module: reg_file_scb

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 8, register count (power of two, >=2); AW = clog2(NUM_REGS).
REQ-003 SHALL have parameter NUM_RD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter BYPASS, default 1, 1 = same-cycle write data forwarded to reads, 0 = reads return the stored value.
REQ-005 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have ports wr0_en / wr1_en  in  1 each  write port enables.
REQ-008 SHALL have ports wr0_addr / wr1_addr  in  AW each  write destinations.
REQ-009 SHALL have ports wr0_data / wr1_data  in  DATA_W each  write data.
REQ-010 SHALL have port wr0_setcc  in  1  update condition codes from the port-0 write.
REQ-011 SHALL have ports rd_addr  in  NUM_RD*AW, rd_data  out  NUM_RD*DATA_W, rd_busy  out  NUM_RD, packed per read port (port k at slice k).
REQ-012 SHALL have ports rsv_valid  in  1, rsv_addr  in  AW, rsv_ready  out  1  scoreboard reservation handshake.
REQ-013 SHALL have port nzp  out  3  LC-3 condition codes {N,Z,P}.

Function
REQ-014 Reads SHALL be combinational: rd_data[k] = mem[rd_addr[k]], with no clock latency.
REQ-015 When BYPASS=1 and a write enable targets rd_addr[k] in the current cycle, rd_data[k] SHALL return that write's data; wr1 SHALL win over wr0.
REQ-016 Writes SHALL take effect on the rising edge of clk when the port enable is 1.
REQ-017 When wr0 and wr1 target the same address in one cycle, wr1_data SHALL be stored.
REQ-018 The scoreboard SHALL hold one busy bit per register.
REQ-019 rd_busy[k] SHALL equal busy[rd_addr[k]] as registered at the start of the cycle.
REQ-020 rsv_ready SHALL equal NOT busy[rsv_addr], OR 1 when a write enable targets rsv_addr in the same cycle (release-and-reserve).
REQ-021 A reservation SHALL be accepted only when rsv_valid AND rsv_ready, setting busy[rsv_addr] on the next edge.
REQ-022 Any enabled write SHALL clear busy for its address on that edge.
REQ-023 If a write and an accepted reservation hit the same address in the same cycle, busy SHALL end at 1.
REQ-024 A reservation with rsv_ready=0 SHALL change no state.
REQ-025 When wr0_en AND wr0_setcc, nzp SHALL update on the edge from wr0_data as a signed DATA_W value: negative gives 100, zero gives 010, positive gives 001.
REQ-026 nzp SHALL hold its value otherwise; a wr1 write SHALL never change nzp.
REQ-027 Writes to a non-busy register SHALL be legal and SHALL leave busy at 0.

Reset
REQ-028 While reset=1, asynchronously, all registers SHALL read 0, all busy bits SHALL be 0, and nzp SHALL be 010.
REQ-029 Reset asserted mid-operation SHALL discard same-cycle writes and reservations.
REQ-030 The first write or reservation SHALL be accepted on the first rising edge with reset=0.

Verification
REQ-031 Reset test: assert reset, read all regs via port 0 -> every rd_data=0x0000, rd_busy=0, nzp=010.
REQ-032 Bypass test: BYPASS=1, wr0 R3<=0xBEEF while rd_addr[0]=3 -> rd_data[0]=0xBEEF same cycle; with BYPASS=0 -> old value, then 0xBEEF next cycle.
REQ-033 Write collision test: wr0 R5<=0x1111 and wr1 R5<=0x2222 in one cycle -> R5 reads 0x2222.
REQ-034 Scoreboard test: reserve R2 -> rsv_ready=0 for R2 next cycle and rd_busy=1 on a port reading R2; wr1 R2<=0x0007 with simultaneous rsv of R2 -> rsv_ready=1 and busy stays 1.
REQ-035 Condition-code test: wr0 0x8000 setcc -> nzp=100; wr0 0x0000 setcc -> 010; wr1 0xFFFF -> nzp stays 010; wr0 0x0001 with setcc=0 -> nzp stays 010.
REQ-036 Async reset test: pulse reset between clock edges while R1 is busy and holds 0x00FF -> outputs clear immediately and busy[1]=0.
